switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce_pkg.sv | 18 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/switch_debounce.sv | 44 ++++
 tb/tb_switch_debounce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_debounce_pkg;

    // 1 ms of stable level at a 50 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Number of switch inputs, matching the downstream PIO in_port.
    localparam int unsigned WIDTH_DEFAULT = 16;

    // Stable-count counter width: ceil(log2(cycles)), never below one bit.
    function automatic int cnt_width(input int unsigned cycles);
        if (cycles < 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: two-flop synchronizer, mismatch counter and
// output flop. update_o is high in the cycle before db_o takes its new value.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic db_o,
    output logic update_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mismatch;
    logic             done;

    // Two-flop synchronizer bringing the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive mismatching samples; accept the new level on the
    // last one. Any matching sample clears the count, so the counter stops
    // at CNT_MAX and never wraps.
    always_comb begin
        mismatch = sync2_q ^ db_q;
        done     = mismatch && (cnt_q == CNT_MAX);
        cnt_d    = '0;
        db_d     = db_q;
        if (done) begin
            db_d = sync2_q;
        end else if (mismatch) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and debounced output state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o     = db_q;
    assign update_o = done;

endmodule

// File: rtl/switch_debounce.sv
// Debouncer for a bank of board switches feeding a PIO in_port. Each bit is
// debounced independently; changed pulses once on any edge that updates
// one or more sw_db bits.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             changed
);

    logic [WIDTH-1:0] update;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_i   (sw_raw[i]),
            .db_o    (sw_db[i]),
            .update_o(update[i])
        );
    end

    // Register the OR of the per-bit strobes so changed rises on the same
    // edge that loads the new sw_db value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |update;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: random and directed switch activity checked
// against a sample-history reference model through an expected-value queue.
module tb_switch_debounce;

    localparam int W  = 16;
    localparam int DC = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic         changed;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .changed(changed)
    );

    int total     = 0;
    int bad       = 0;
    int chg_seen  = 0;
    int fail_prints = 0;

    // Expected {sw_db, changed} after each rising edge.
    logic [W:0] exp_q[$];

    // ---------------- reference model ----------------
    // Keeps the raw words sampled on the last two edges (the synchronizer
    // delay) and, per bit, the length of the current run of samples that
    // disagree with the debounced level. The DC-th disagreeing sample in a
    // row flips the level.
    logic [W-1:0] m_db;
    int           m_run[W];
    logic [W-1:0] m_hist[$];

    task automatic model_reset();
        m_db = '0;
        for (int b = 0; b < W; b++) m_run[b] = 0;
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
    endtask

    always @(posedge clk) begin
        logic [W-1:0] seen;
        logic         chg;
        if (!reset_n) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            seen = m_hist.pop_front();
            chg  = 1'b0;
            for (int b = 0; b < W; b++) begin
                if (seen[b] != m_db[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DC) begin
                        m_db[b]  = seen[b];
                        m_run[b] = 0;
                        chg      = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_hist.push_back(sw_raw);
            exp_q.push_back({m_db, chg});
        end
    end

    // Asynchronous reset clears outputs immediately, overriding whatever
    // was queued for the current cycle.
    always @(negedge reset_n) begin
        model_reset();
        if (exp_q.size() != 0) begin
            exp_q.delete();
            exp_q.push_back('0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W:0] e;
        total = total + 1;
        if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_underflow t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({sw_db, changed} !== e) begin
                bad = bad + 1;
                if (fail_prints < 20) begin
                    fail_prints = fail_prints + 1;
                    $display("FAIL scoreboard t=%0t sw_db=%h changed=%b expected sw_db=%h changed=%b",
                             $time, sw_db, changed, e[W:1], e[0]);
                end
            end
        end
        if (changed === 1'b1) chg_seen = chg_seen + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           c0;
        logic [W-1:0] nxt;
        int           rate;

        model_reset();
        reset_n = 1'b0;
        sw_raw  = '0;
        tick(3);
        reset_n = 1'b1;

        // Idle: all switches low.
        tick(12);
        check("idle_db", 32'(sw_db), 32'h0);
        check("idle_changed_count", 32'(chg_seen), 32'd0);

        // Single bit rising: visible after E0+DC+1.
        c0     = chg_seen;
        sw_raw = 16'h0001;
        tick(5);
        check("lat_before_db", 32'(sw_db), 32'h0);
        tick(1);
        check("lat_db", 32'(sw_db), 32'h1);
        check("lat_changed", 32'(changed), 32'd1);
        tick(1);
        check("lat_changed_drop", 32'(changed), 32'd0);
        check("lat_pulses", 32'(chg_seen - c0), 32'd1);

        // Bit3 glitch of DC-1 samples, twice: must never reach sw_db.
        c0 = chg_seen;
        for (int k = 0; k < 2; k++) begin
            sw_raw = 16'h0009;
            tick(DC - 1);
            sw_raw = 16'h0001;
            tick(12);
        end
        check("glitch_db", 32'(sw_db), 32'h1);
        check("glitch_pulses", 32'(chg_seen - c0), 32'd0);

        // Several bits together: single edge, single pulse.
        sw_raw = '0;
        tick(10);
        c0     = chg_seen;
        sw_raw = 16'h8081;
        tick(5);
        check("multi_before_db", 32'(sw_db), 32'h0);
        tick(1);
        check("multi_db", 32'(sw_db), 32'h8081);
        check("multi_changed", 32'(changed), 32'd1);
        tick(3);
        check("multi_pulses", 32'(chg_seen - c0), 32'd1);

        // Reset mid-count on bit5 (count reaches 2 after E0+3).
        sw_raw = 16'h80A1;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("rst_async_db", 32'(sw_db), 32'h0);
        check("rst_async_changed", 32'(changed), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        check("rst_before_db", 32'(sw_db), 32'h0);
        tick(1);
        check("rst_after_db", 32'(sw_db), 32'h80A1);
        check("rst_after_changed", 32'(changed), 32'd1);

        // Random bouncing on all bits with a varying bounce rate.
        nxt  = sw_raw;
        rate = 4;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (cyc % 256 == 0) rate = int'($urandom_range(2, 24));
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, rate - 1) == 0) nxt[b] = ~nxt[b];
            end
            sw_raw = nxt;
            if ($urandom_range(0, 4999) == 0) pulse_reset();
            else tick(1);
        end

        tick(3);
        check("queue_depth", 32'(exp_q.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
